// File: rtl/fetch_ctrl.sv
// Fetch controller: next-PC select, stall/flush control and a small FSM.
// Redirects that arrive while memory is stalled are held until it is ready.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        imem_ready,
    input  logic        load_use_hazard,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap,
    output logic [31:0] din,
    output logic        pc_pc_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    // Redirect priority levels; 0 means no redirect
    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_JMP  = 2'd1;
    localparam logic [1:0] LVL_BR   = 2'd2;
    localparam logic [1:0] LVL_TRAP = 2'd3;

    state_t      cur;
    state_t      nxt;
    logic [1:0]  pend_lvl;
    logic [31:0] pend_tgt;
    logic [1:0]  ev_lvl;
    logic [31:0] ev_tgt;
    logic [1:0]  eff_lvl;
    logic [31:0] eff_tgt;
    logic [31:0] pc_inc;
    logic        redir;

    assign state  = cur;
    assign pc_inc = pc + 32'd4;

    // Pick the highest-priority redirect event this cycle
    always_comb begin
        ev_lvl = LVL_NONE;
        ev_tgt = 32'd0;
        if (trap) begin
            ev_lvl = LVL_TRAP;
            ev_tgt = TRAP_VEC;
        end else if (branch_taken) begin
            ev_lvl = LVL_BR;
            ev_tgt = branch_target;
        end else if (jump) begin
            ev_lvl = LVL_JMP;
            ev_tgt = jump_target;
        end
    end

    // Merge a same-cycle event with the held one, keeping the stronger
    always_comb begin
        eff_lvl = pend_lvl;
        eff_tgt = pend_tgt;
        if (ev_lvl > pend_lvl) begin
            eff_lvl = ev_lvl;
            eff_tgt = ev_tgt;
        end
    end

    // Next-PC, pipeline controls and next state
    always_comb begin
        din         = pc_inc;
        pc_pc_stall = 1'b0;
        IF_ID_stall = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        redir       = 1'b0;
        nxt         = cur;
        case (cur)
            BOOT: begin
                din         = RESET_PC;
                pc_pc_stall = 1'b1;
                nxt         = RUN;
            end
            RUN, REDIRECT: begin
                if (ev_lvl != LVL_NONE) begin
                    din         = ev_tgt;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = (ev_lvl != LVL_JMP);
                    redir       = 1'b1;
                    nxt         = REDIRECT;
                end else if (cur == RUN && load_use_hazard) begin
                    din         = pc;
                    pc_pc_stall = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                    nxt         = RUN;
                end else if (!imem_ready) begin
                    din         = pc;
                    pc_pc_stall = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                    nxt         = WAIT_MEM;
                end else begin
                    IF_ID_flush = (cur == REDIRECT);
                    nxt         = RUN;
                end
            end
            WAIT_MEM: begin
                if (!imem_ready) begin
                    din         = pc;
                    pc_pc_stall = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (eff_lvl != LVL_NONE) begin
                    din         = eff_tgt;
                    IF_ID_flush = 1'b1;
                    redir       = 1'b1;
                    nxt         = REDIRECT;
                end else begin
                    nxt = RUN;
                end
            end
            default: nxt = BOOT;
        endcase
    end

    // State, held redirect and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= BOOT;
            pend_lvl     <= LVL_NONE;
            pend_tgt     <= 32'd0;
            stall_cnt    <= 16'd0;
            redirect_cnt <= 16'd0;
        end else begin
            cur <= nxt;
            if (cur == WAIT_MEM) begin
                if (imem_ready) begin
                    pend_lvl <= LVL_NONE;
                end else if (ev_lvl > pend_lvl) begin
                    pend_lvl <= ev_lvl;
                    pend_tgt <= ev_tgt;
                end
            end
            if (pc_pc_stall && (cur == RUN || cur == WAIT_MEM)
                && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (redir && redirect_cnt != 16'hFFFF) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl.
// Inputs change 1 time unit after the rising edge; outputs checked 1 unit later.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_ready;
    logic        load_use_hazard;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic [31:0] din;
    logic        pc_pc_stall;
    logic        IF_ID_stall;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .imem_ready(imem_ready),
        .load_use_hazard(load_use_hazard),
        .jump(jump),
        .jump_target(jump_target),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .trap(trap),
        .din(din),
        .pc_pc_stall(pc_pc_stall),
        .IF_ID_stall(IF_ID_stall),
        .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush),
        .state(state),
        .stall_cnt(stall_cnt),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic rdy,
                         input logic luh, input logic j,
                         input logic [31:0] jt, input logic b,
                         input logic [31:0] bt, input logic t);
        pc              = p;
        imem_ready      = rdy;
        load_use_hazard = luh;
        jump            = j;
        jump_target     = jt;
        branch_taken    = b;
        branch_target   = bt;
        trap            = t;
        #1;
    endtask

    // Check the four pipeline controls as one packed nibble
    task automatic ctl(input string tag, input logic [3:0] exp);
        chk(tag, 32'({pc_pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush}),
            32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_scnt", 32'(stall_cnt), 32'd0);
        chk("rst_rcnt", 32'(redirect_cnt), 32'd0);
        rst = 1'b0;

        // Boot and straight-line fetch
        drive(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("boot_din", din, 32'h0);
        ctl("boot_ctl", 4'b1000);
        tick();
        chk("run0_state", 32'(state), 32'd1);
        drive(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("run0_din", din, 32'h4);
        tick();
        drive(32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("run1_din", din, 32'h8);
        tick();
        drive(32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("run2_din", din, 32'hC);
        chk("run2_state", 32'(state), 32'd1);
        ctl("run2_ctl", 4'b0000);
        chk("run2_scnt", 32'(stall_cnt), 32'd0);
        tick();

        // Load-use hazard
        drive(32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("luh_din", din, 32'h10);
        ctl("luh_ctl", 4'b1101);
        tick();
        drive(32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("luh_next_din", din, 32'h14);
        chk("luh_scnt", 32'(stall_cnt), 32'd1);
        chk("luh_state", 32'(state), 32'd1);
        tick();

        // Branch beats jump in the same cycle
        drive(32'h20, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        chk("br_din", din, 32'h80);
        ctl("br_ctl", 4'b0011);
        tick();
        chk("br_state", 32'(state), 32'd3);
        chk("br_rcnt", 32'(redirect_cnt), 32'd1);
        drive(32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("redir_din", din, 32'h84);
        ctl("redir_ctl", 4'b0010);
        tick();
        chk("redir_state", 32'(state), 32'd1);

        // PC wrap
        drive(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wrap_din", din, 32'h0);

        // Jump alone, then trap while in REDIRECT
        drive(32'h30, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        chk("jmp_din", din, 32'h300);
        ctl("jmp_ctl", 4'b0010);
        tick();
        chk("jmp_state", 32'(state), 32'd3);
        drive(32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("trap_din", din, 32'h100);
        ctl("trap_ctl", 4'b0011);
        tick();
        chk("trap_state", 32'(state), 32'd3);
        chk("trap_rcnt", 32'(redirect_cnt), 32'd3);
        drive(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("trap_seq_din", din, 32'h104);
        tick();

        // Memory stall with a jump held until ready
        drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wm0_din", din, 32'h40);
        ctl("wm0_ctl", 4'b1101);
        tick();
        chk("wm0_state", 32'(state), 32'd2);
        drive(32'h40, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        chk("wm1_din", din, 32'h40);
        ctl("wm1_ctl", 4'b1101);
        tick();
        drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wm2_din", din, 32'h40);
        tick();
        drive(32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wm_rel_din", din, 32'h200);
        ctl("wm_rel_ctl", 4'b0010);
        tick();
        chk("wm_rel_state", 32'(state), 32'd3);
        chk("wm_scnt", 32'(stall_cnt), 32'd4);
        chk("wm_rcnt", 32'(redirect_cnt), 32'd4);
        drive(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wm_after_din", din, 32'h204);
        tick();
        chk("wm_after_state", 32'(state), 32'd1);

        // Held-redirect priority: branch kept over later jump
        drive(32'h50, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h50, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h50, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
        tick();
        drive(32'h50, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h50, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("prio_din", din, 32'h600);
        tick();
        chk("prio_rcnt", 32'(redirect_cnt), 32'd5);
        chk("prio_scnt", 32'(stall_cnt), 32'd8);
        drive(32'h600, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Reset mid-stall drops a held trap
        drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        rst = 1'b1;
        drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_scnt", 32'(stall_cnt), 32'd0);
        drive(32'h60, 1'b0, 1'b1, 1'b1, 32'h900, 1'b1, 32'h800, 1'b1);
        chk("boot_ign_din", din, 32'h0);
        ctl("boot_ign_ctl", 4'b1000);
        tick();
        drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("rst2_wm_state", 32'(state), 32'd2);
        drive(32'h60, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst2_rel_din", din, 32'h64);
        ctl("rst2_rel_ctl", 4'b0000);
        tick();
        chk("rst2_rel_state", 32'(state), 32'd1);

        // Stall counter saturation, then reset
        drive(32'h70, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("sat_scnt", 32'(stall_cnt), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sat_rst_scnt", 32'(stall_cnt), 32'd0);
        chk("sat_rst_state", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
